// File: rtl/merlin_mem_arbiter.sv
// Two-to-one arbiter sharing one memory bus between the merlin32i I and D ports.
// Round-robin grant with stall lock; in-order responses routed by an owner-tag FIFO.
module merlin_mem_arbiter #(
    parameter int C_OUTST_X = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic        dreqwr_i,
    input  logic [3:0]  dreqbe_i,
    input  logic [31:0] dreqwdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,
    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic        mreqwr_o,
    output logic [3:0]  mreqbe_o,
    output logic [31:0] mreqwdata_o,
    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i
);

    localparam int DEPTH = 1 << C_OUTST_X;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    owner_e                 last_q, last_d;
    owner_e                 lock_own_q, lock_own_d;
    logic                   lock_q, lock_d;
    logic [C_OUTST_X-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_OUTST_X-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_OUTST_X:0]     count_q, count_d;
    owner_e                 tag_mem_q [DEPTH];

    owner_e owner;
    owner_e head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   own_valid;
    logic   accept;
    logic   pop;

    assign fifo_full  = (count_q == (C_OUTST_X+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    always_comb begin
        owner = (last_q == OWN_I) ? OWN_D : OWN_I;
        if (lock_q) begin
            owner = lock_own_q;
        end else if (ireqvalid_i && !dreqvalid_i) begin
            owner = OWN_I;
        end else if (dreqvalid_i && !ireqvalid_i) begin
            owner = OWN_D;
        end
    end

    assign own_valid = (owner == OWN_D) ? dreqvalid_i : ireqvalid_i;

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        mreqvalid_o = 1'b0;
        mreqhpl_o   = '0;
        mreqaddr_o  = '0;
        mreqwr_o    = 1'b0;
        mreqbe_o    = '0;
        mreqwdata_o = '0;
        ireqready_o = 1'b0;
        dreqready_o = 1'b0;
        mrspready_o = 1'b0;
        irspvalid_o = 1'b0;
        irsprerr_o  = 1'b0;
        irspdata_o  = '0;
        drspvalid_o = 1'b0;
        drsprerr_o  = 1'b0;
        drspwerr_o  = 1'b0;
        drspdata_o  = '0;
        if (!reset_i) begin
            mreqvalid_o = own_valid && !fifo_full;
            if (owner == OWN_D) begin
                mreqhpl_o   = dreqhpl_i;
                mreqaddr_o  = dreqaddr_i;
                mreqwr_o    = dreqwr_i;
                mreqbe_o    = dreqbe_i;
                mreqwdata_o = dreqwdata_i;
                dreqready_o = mreqready_i && !fifo_full;
            end else begin
                mreqhpl_o   = ireqhpl_i;
                mreqaddr_o  = ireqaddr_i;
                mreqbe_o    = 4'hF;
                ireqready_o = mreqready_i && !fifo_full;
            end
            mrspready_o = !fifo_empty && ((head == OWN_D) ? drspready_i : irspready_i);
            irspvalid_o = mrspvalid_i && !fifo_empty && (head == OWN_I);
            drspvalid_o = mrspvalid_i && !fifo_empty && (head == OWN_D);
            irsprerr_o  = mrsprerr_i;
            irspdata_o  = mrspdata_i;
            drsprerr_o  = mrsprerr_i;
            drspwerr_o  = mrspwerr_i;
            drspdata_o  = mrspdata_i;
        end
    end

    assign accept = mreqvalid_o && mreqready_i;
    assign pop    = mrspvalid_i && mrspready_o;

    always_comb begin
        last_d     = last_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (accept) begin
            last_d   = owner;
            lock_d   = 1'b0;
            wr_ptr_d = wr_ptr_q + C_OUTST_X'(1);
        end else if (mreqvalid_o) begin
            // Stalled request: pin the grant until the memory takes it.
            lock_d     = 1'b1;
            lock_own_d = owner;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_OUTST_X'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + (C_OUTST_X+1)'(1);
            2'b01:   count_d = count_q - (C_OUTST_X+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q     <= OWN_I;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_I;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (clk_en_i) begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: tag storage is not reset; only entries between the pointers are read, and the count is reset.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && accept) begin
            tag_mem_q[wr_ptr_q] <= owner;
        end
    end

endmodule
